// File: rtl/spi_pkg.sv
// Shared defaults and types for the SPI frame sequencer slice.
package spi_pkg;

    localparam int DATA_WIDTH = 2;
    localparam int DATA_DEPTH = 16;
    localparam int FRAME_BITS = DATA_WIDTH * DATA_DEPTH;
    localparam int IDX_BITS   = $clog2(DATA_DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } drain_state_t;

endpackage

// File: rtl/spi_frame_sequencer_if.sv
// Cell stream from the frame sequencer to the game/display logic (valid/ready).
interface spi_frame_sequencer_if #(
    parameter int DATA_WIDTH = spi_pkg::DATA_WIDTH,
    parameter int DATA_DEPTH = spi_pkg::DATA_DEPTH
);
    logic [DATA_WIDTH-1:0]         cell_out;
    logic [$clog2(DATA_DEPTH)-1:0] cell_idx;
    logic                          cell_last;
    logic                          cell_valid;
    logic                          cell_ready;

    modport master (output cell_out, output cell_idx, output cell_last,
                    output cell_valid, input cell_ready);
    modport slave  (input cell_out, input cell_idx, input cell_last,
                    input cell_valid, output cell_ready);
endinterface

// File: rtl/posedge_detector.sv
// Registered single-cycle pulse on a rising edge of a synchronous level.
module posedge_detector (
    input  logic clk,
    input  logic nrst,
    input  logic sig,
    output logic pulse
);
    logic prev_r;
    logic pulse_r;

    // remember the last level and flag a 0->1 transition
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev_r  <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            prev_r  <= sig;
            pulse_r <= sig & ~prev_r;
        end
    end

    assign pulse = pulse_r;
endmodule

// File: rtl/spi_watchdog.sv
// Transfer watchdog: armed by an spi_en rise, expires after TIMEOUT_CYCLES counts.
module spi_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic nrst,
    input  logic arm,
    input  logic disarm,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic             armed_r;
    logic [CNT_W-1:0] cnt_r;

    assign expired = armed_r & (cnt_r == CNT_MAX);

    // arm/disarm and saturating count; expiry disarms so it pulses once
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            armed_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (arm) begin
            armed_r <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (armed_r) begin
            if (disarm || expired) begin
                armed_r <= 1'b0;
            end else if (count_en && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/syncronizer.sv
// Multi-flop synchronizer for a single asynchronous level.
module syncronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_r;

    // shift the raw level through the synchronizer chain
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];
endmodule

// File: rtl/spi_frame_sequencer.sv
// Captures SPI frames into a one-deep pending slot and streams them out cell by cell,
// with sticky overrun/timeout supervision and a completed-frame counter.
module spi_frame_sequencer #(
    parameter int DATA_WIDTH     = spi_pkg::DATA_WIDTH,
    parameter int DATA_DEPTH     = spi_pkg::DATA_DEPTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           spi_en,
    input  logic                           valid_data,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] frame_in,
    spi_frame_sequencer_if.master          cell_if,
    input  logic                           clear_err,
    output logic                           overrun,
    output logic                           timeout,
    output logic [7:0]                     frame_cnt
);
    import spi_pkg::drain_state_t;
    import spi_pkg::IDLE;
    import spi_pkg::STREAM;

    localparam int FRAME_W = DATA_WIDTH * DATA_DEPTH;
    localparam int IDX_W   = $clog2(DATA_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_DEPTH - 1);

    logic [FRAME_W-1:0] pend_r;
    logic [FRAME_W-1:0] active_r;
    logic               pend_full_r;
    drain_state_t       state_r;
    logic [IDX_W-1:0]   idx_r;
    logic               valid_r;
    logic               last_r;
    logic               overrun_r;
    logic               timeout_r;
    logic [7:0]         frame_cnt_r;

    logic spi_en_sync_s;
    logic spi_rise_s;
    logic expired_s;
    logic handshake_s;
    logic last_hs_s;
    logic load_pend_s;
    logic bypass_s;
    logic capture_s;
    logic drop_s;

    syncronizer #(.STAGES(2)) u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (spi_en),
        .q    (spi_en_sync_s)
    );

    posedge_detector u_rise (
        .clk   (clk),
        .nrst  (nrst),
        .sig   (spi_en_sync_s),
        .pulse (spi_rise_s)
    );

    spi_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
        .clk      (clk),
        .nrst     (nrst),
        .arm      (spi_rise_s),
        .disarm   (valid_data | ~spi_en_sync_s),
        .count_en (spi_en_sync_s),
        .expired  (expired_s)
    );

    assign handshake_s = valid_r & cell_if.cell_ready;
    assign last_hs_s   = handshake_s & last_r;
    assign load_pend_s = pend_full_r & ((state_r == IDLE) | last_hs_s);
    // a frame landing on the last handshake goes straight to the active register
    assign bypass_s    = last_hs_s & ~pend_full_r & valid_data;
    assign capture_s   = valid_data & ~pend_full_r & ~bypass_s;
    assign drop_s      = valid_data & pend_full_r;

    // pending slot: fill on capture, empty when the drain side takes it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pend_r      <= {FRAME_W{1'b0}};
            pend_full_r <= 1'b0;
        end else if (capture_s) begin
            pend_r      <= frame_in;
            pend_full_r <= 1'b1;
        end else if (load_pend_s) begin
            pend_full_r <= 1'b0;
        end
    end

    // drain FSM: load a frame, then shift one cell out per handshake
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r  <= IDLE;
            active_r <= {FRAME_W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
        end else if (load_pend_s || bypass_s) begin
            state_r  <= STREAM;
            active_r <= load_pend_s ? pend_r : frame_in;
            idx_r    <= {IDX_W{1'b0}};
            valid_r  <= 1'b1;
            last_r   <= (IDX_LAST == {IDX_W{1'b0}});
        end else if (handshake_s) begin
            active_r <= {active_r[FRAME_W-DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
            if (last_r) begin
                state_r <= IDLE;
                idx_r   <= {IDX_W{1'b0}};
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
                last_r <= ((idx_r + IDX_W'(1)) == IDX_LAST);
            end
        end
    end

    // sticky flags (a set beats a same-cycle clear) and completed-frame counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            overrun_r   <= 1'b0;
            timeout_r   <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            overrun_r <= drop_s | (overrun_r & ~clear_err);
            timeout_r <= expired_s | (timeout_r & ~clear_err);
            if (last_hs_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
        end
    end

    assign cell_if.cell_out   = active_r[FRAME_W-1 -: DATA_WIDTH];
    assign cell_if.cell_idx   = idx_r;
    assign cell_if.cell_last  = last_r;
    assign cell_if.cell_valid = valid_r;
    assign overrun            = overrun_r;
    assign timeout            = timeout_r;
    assign frame_cnt          = frame_cnt_r;
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Directed self-checking bench for spi_frame_sequencer (W=2, D=16, timeout 16).
module tb_spi_frame_sequencer;
    localparam int W = 2;
    localparam int D = 16;
    localparam int T = 16;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          spi_en = 1'b0;
    logic          valid_data = 1'b0;
    logic [W*D-1:0] frame_in = 32'h0;
    logic          clear_err = 1'b0;
    logic          overrun;
    logic          timeout;
    logic [7:0]    frame_cnt;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    spi_frame_sequencer_if #(.DATA_WIDTH(W), .DATA_DEPTH(D)) cell_if ();

    spi_frame_sequencer #(.DATA_WIDTH(W), .DATA_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .spi_en     (spi_en),
        .valid_data (valid_data),
        .frame_in   (frame_in),
        .cell_if    (cell_if.master),
        .clear_err  (clear_err),
        .overrun    (overrun),
        .timeout    (timeout),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] f);
        valid_data = 1'b1;
        frame_in   = f;
        tick();
        valid_data = 1'b0;
    endtask

    function automatic logic [1:0] cell_of(input logic [31:0] f, input int k);
        logic [31:0] s;
        s = f >> (30 - 2 * k);
        return s[1:0];
    endfunction

    task automatic check_cell(input string tag, input logic [31:0] f, input int k);
        check_val({tag, "_valid"}, 32'(cell_if.cell_valid), 32'd1);
        check_val({tag, "_cell"},  32'(cell_if.cell_out), 32'(cell_of(f, k)));
        check_val({tag, "_idx"},   32'(cell_if.cell_idx), 32'(k));
        check_val({tag, "_last"},  32'(cell_if.cell_last), 32'(k == D - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [31:0] fa;
        logic [31:0] fb;
        int k;
        int p;

        cell_if.cell_ready = 1'b1;
        tick();
        tick();
        // reset state
        check_val("rst_valid",   32'(cell_if.cell_valid), 32'd0);
        check_val("rst_idx",     32'(cell_if.cell_idx), 32'd0);
        check_val("rst_cell",    32'(cell_if.cell_out), 32'd0);
        check_val("rst_last",    32'(cell_if.cell_last), 32'd0);
        check_val("rst_overrun", 32'(overrun), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_cnt",     32'(frame_cnt), 32'd0);
        nrst = 1'b1;
        tick();

        // single frame 0xE4E4E4E4: cells 3,2,1,0 repeating
        send_frame(32'hE4E4_E4E4);
        check_val("t1_latency_low", 32'(cell_if.cell_valid), 32'd0);
        tick();
        for (int i = 0; i < D; i++) begin
            check_val("t1_valid", 32'(cell_if.cell_valid), 32'd1);
            check_val("t1_cell", 32'(cell_if.cell_out), 32'(3 - (i % 4)));
            check_val("t1_idx", 32'(cell_if.cell_idx), 32'(i));
            check_val("t1_last", 32'(cell_if.cell_last), 32'(i == 15));
            tick();
        end
        check_val("t1_done_valid", 32'(cell_if.cell_valid), 32'd0);
        check_val("t1_frame_cnt", 32'(frame_cnt), 32'd1);

        // backpressure pattern 1,0,0,1
        fa = 32'h1B6C_93D2;
        send_frame(fa);
        tick();
        k = 0;
        p = 0;
        while (k < D && p < 100) begin
            check_cell("t2", fa, k);
            cell_if.cell_ready = ((p % 4) == 0) || ((p % 4) == 3);
            if (cell_if.cell_ready) k++;
            p++;
            tick();
        end
        cell_if.cell_ready = 1'b1;
        check_val("t2_all_cells", 32'(k), 32'd16);
        check_val("t2_done_valid", 32'(cell_if.cell_valid), 32'd0);
        check_val("t2_frame_cnt", 32'(frame_cnt), 32'd2);

        // frame B arrives while A streams: no gap between frames
        fa = 32'hA5F0_3C96;
        fb = 32'h0FE1_7B24;
        send_frame(fa);
        tick();
        for (int i = 0; i < 2 * D; i++) begin
            if (i < D) check_cell("t3a", fa, i);
            else       check_cell("t3b", fb, i - D);
            valid_data = (i == 5);
            frame_in   = fb;
            tick();
        end
        valid_data = 1'b0;
        check_val("t3_done_valid", 32'(cell_if.cell_valid), 32'd0);
        check_val("t3_frame_cnt", 32'(frame_cnt), 32'd4);

        // three frames with ready low: third dropped, overrun sticky
        cell_if.cell_ready = 1'b0;
        fa = 32'h1234_5678;
        fb = 32'h9ABC_DEF0;
        send_frame(fa);
        tick(); tick(); tick();
        send_frame(fb);
        tick(); tick(); tick();
        check_val("t4_no_overrun", 32'(overrun), 32'd0);
        send_frame(32'hFFFF_0000);
        check_val("t4_overrun", 32'(overrun), 32'd1);
        check_val("t4_hold_cell", 32'(cell_if.cell_out), 32'(cell_of(fa, 0)));
        check_val("t4_hold_idx", 32'(cell_if.cell_idx), 32'd0);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_val("t4_cleared", 32'(overrun), 32'd0);
        clear_err = 1'b1;
        send_frame(32'h5555_AAAA);
        clear_err = 1'b0;
        check_val("t4_set_beats_clear", 32'(overrun), 32'd1);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        check_val("t4_cleared2", 32'(overrun), 32'd0);
        cell_if.cell_ready = 1'b1;
        for (int i = 0; i < 2 * D; i++) begin
            if (i < D) check_cell("t4a", fa, i);
            else       check_cell("t4b", fb, i - D);
            tick();
        end
        check_val("t4_done_valid", 32'(cell_if.cell_valid), 32'd0);
        check_val("t4_frame_cnt", 32'(frame_cnt), 32'd6);

        // watchdog expires 16 counts after arming (3 cycles after spi_en rises)
        spi_en = 1'b1;
        for (int i = 0; i < 19; i++) tick();
        check_val("t5_not_yet", 32'(timeout), 32'd0);
        tick();
        check_val("t5_timeout", 32'(timeout), 32'd1);
        spi_en    = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tick(); tick(); tick();
        check_val("t5_cleared", 32'(timeout), 32'd0);
        // valid_data at count 10 disarms it
        spi_en = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        send_frame(32'hC3C3_3C3C);
        for (int i = 0; i < 30; i++) tick();
        check_val("t5_no_timeout", 32'(timeout), 32'd0);
        check_val("t5_frame_cnt", 32'(frame_cnt), 32'd7);
        spi_en = 1'b0;

        // reset at idx 7 with a frame pending
        fa = 32'h6789_ABCD;
        send_frame(fa);
        tick();
        for (int i = 0; i < 7; i++) begin
            valid_data = (i == 3);
            frame_in   = 32'hDEAD_BEEF;
            tick();
        end
        valid_data = 1'b0;
        check_val("t6_idx7", 32'(cell_if.cell_idx), 32'd7);
        nrst = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(cell_if.cell_valid), 32'd0);
        check_val("t6_rst_idx",   32'(cell_if.cell_idx), 32'd0);
        check_val("t6_rst_cell",  32'(cell_if.cell_out), 32'd0);
        check_val("t6_rst_last",  32'(cell_if.cell_last), 32'd0);
        check_val("t6_rst_cnt",   32'(frame_cnt), 32'd0);
        tick();
        nrst = 1'b1;
        tick(); tick(); tick(); tick();
        check_val("t6_pend_dropped", 32'(cell_if.cell_valid), 32'd0);
        fb = 32'h8421_7EB4;
        send_frame(fb);
        tick();
        check_cell("t6_fresh", fb, 0);
        for (int i = 0; i < D; i++) tick();
        check_val("t6_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/spi_frame_sequencer.md
# spi_frame_sequencer

Controller downstream of the SPI receive shift register. Captures each completed SPI frame (one `valid_data` pulse plus a parallel word), holds one frame pending, and streams the active frame out one cell at a time over a valid/ready handshake to the game/display logic. It also owns link supervision: sticky overrun and transfer-timeout flags, plus a completed-frame counter.

## Interface
Parameters
- `DATA_WIDTH`, 2: bits per cell.
- `DATA_DEPTH`, 16: cells per frame.
- `TIMEOUT_CYCLES`, 4096: clk cycles allowed from the spi_en rise to `valid_data`.

Ports
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous active-low reset.
- `spi_en`  in  1  raw, asynchronous SPI enable; synchronized internally with a 2-flop synchronizer.
- `valid_data`  in  1  one-cycle pulse: `frame_in` is complete.
- `frame_in`  in  DATA_WIDTH*DATA_DEPTH  frame word, sampled only when `valid_data` is high.
- `cell_out`  out  DATA_WIDTH  current cell.
- `cell_idx`  out  $clog2(DATA_DEPTH)  index of `cell_out`, 0..DATA_DEPTH-1.
- `cell_last`  out  1  high with `cell_valid` when `cell_idx` == DATA_DEPTH-1.
- `cell_valid`  out  1  `cell_out`, `cell_idx` and `cell_last` are valid.
- `cell_ready`  in  1  consumer accepts the cell.
- `clear_err`  in  1  synchronous clear of the sticky flags.
- `overrun`  out  1  sticky: a frame was dropped.
- `timeout`  out  1  sticky: the watchdog expired.
- `frame_cnt`  out  8  frames fully drained; wraps from 255 to 0.

## Operation
- Cell order: cell k = `frame_in[W*D-1-k*W -: W]`. Cell 0 is the MSB pair, which is the first data received.
- Capture side: a pending register plus a `pend_full` flag.
  - `valid_data` with `pend_full`=0 stores the frame and sets `pend_full`.
  - `valid_data` with `pend_full`=1 drops the new frame, sets `overrun`, and leaves the pending frame intact.
- Drain FSM, states IDLE and STREAM.
  - IDLE: if `pend_full`, load pending into the active register, clear `pend_full`, set idx=0, go to STREAM.
  - STREAM: `cell_valid`=1. A handshake is `cell_valid && cell_ready`; each handshake increments idx.
  - A handshake with `cell_last` increments `frame_cnt`.
    - If `pend_full` (or a frame captured that cycle is visible as `pend_full`): reload directly, idx=0, stay in STREAM, no bubble.
    - Otherwise go to IDLE.
  - With `cell_ready`=0, all cell outputs hold stable.
- Watchdog:
  - Arms on the synchronized spi_en rising edge and clears its count.
  - Counts while armed and spi_en_sync=1.
  - Disarms on `valid_data` or on spi_en_sync falling.
  - When the count reaches TIMEOUT_CYCLES-1 while armed: set `timeout` and disarm.
  - A new spi_en rise re-arms it.
- Sticky flags: `clear_err` clears `overrun` and `timeout`. A set event in the same cycle as `clear_err` wins (flag ends 1).

## Timing
- Reset values: `cell_out`=0, `cell_idx`=0, `cell_last`=0, `cell_valid`=0, `overrun`=0, `timeout`=0, `frame_cnt`=0. FSM=IDLE, `pend_full`=0, watchdog disarmed.
- Latency: `valid_data` high in cycle t, pending written at edge t; IDLE loads at edge t+1; `cell_valid` high in cycle t+2.
- Back-to-back frames: a sustained `cell_ready`=1 gives D cells per D cycles. Frames must arrive no faster than D cycles apart, or `overrun` sets.
- The spi_en synchronizer adds 2 cycles, and edge detection 1 more, before the watchdog arms.
- Reset mid-stream aborts immediately. The partial frame and the pending frame are discarded.
- The watchdog counter width is $clog2(TIMEOUT_CYCLES), saturating. It never wraps.

## Structure
- Shared package `spi_pkg` holds the default DATA_WIDTH/DATA_DEPTH, derived FRAME_BITS and IDX_BITS, and the `drain_state_t` enum {IDLE, STREAM}.
- Reuse the existing `syncronizer` and `posedge_detector` for spi_en.
- One natural new sub-module, `spi_watchdog`: arm/disarm inputs, count, `expired` pulse.

## Test plan
- Single frame 0xE4E4_E4E4 with `cell_ready`=1:
  - `cell_valid` rises 2 cycles after `valid_data`.
  - Cells are 3,2,1,0 repeating, idx 0..15, `cell_last` at idx 15.
  - `frame_cnt`=1, then `cell_valid`=0.
- Backpressure: `cell_ready` toggled 1,0,0,1,… → every cell appears exactly once in order, and outputs stay stable while `cell_ready`=0.
- Frame B arrives while frame A is streaming → B is cell 0 on the cycle after A's last handshake with no `cell_valid` gap; `frame_cnt`=2.
- Three frames with `cell_ready`=0 → first two retained; third dropped with `overrun`=1. `clear_err` clears it, and `overrun` stays 1 if a drop coincides with the clear.
- Watchdog: spi_en rises, no `valid_data` for TIMEOUT_CYCLES (sim parameter 16) → `timeout`=1. If `valid_data` arrives at count 10, `timeout` stays 0.
- Assert `nrst` at idx 7 → all outputs return to reset values. A following fresh frame streams from idx 0.
